// File: rtl/wkld_dispatcher.sv
// -----------------------------------------------------------------------------
// wkld_dispatcher
//
// Purpose
//   Accepts one tile descriptor at a time and hands each compute unit (CU) its
//   slice of rows. The tile carries row pointers, a row-to-row map and a list
//   of N_PE+1 workload pointers. CU i owns rows [wkld_ptr[i], wkld_ptr[i+1]),
//   and an empty slice is skipped. The block loads the CUs one per cycle in
//   ascending order, then waits until every loaded CU has reported completion.
//   It then pulses tile_done and is ready for the next tile.
//
// Ports
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   tile_valid    : tile descriptor offered (input)
//   tile_ready    : dispatcher can take a descriptor (output, high in IDLE)
//   tile_data     : descriptor, LSB first:
//                   row_ptrs[(M+1)*DW_ELEIDX], row2row[M*DW_ROWIDX],
//                   wkld_ptr[0..N_PE] each DW_ROWIDX
//   cu_write_en   : one-hot load strobe, one bit per CU
//   cu_data       : shared load bus, LSB first:
//                   row_ptrs, row2row, start, end, upper bits zero.
//                   The bus holds its last value while no strobe is active.
//   cu_done       : per-CU single-cycle completion pulse
//   tile_done     : one-cycle pulse when the tile is finished
//   busy          : high whenever the dispatcher is not IDLE
//   tmo_err       : one-cycle watchdog pulse (always 0 unless the watchdog is built)
//   dbg_state     : current FSM state encoding
//
// Handshake
//   A descriptor transfers on a rising edge where tile_valid && tile_ready.
//   tile_ready does not depend on tile_valid. Once tile_valid is raised, it
//   must stay raised until the transfer happens.
//
// Configuration
//   `define DISPATCH_TIMEOUT_EN builds a WAIT-state watchdog.
//   - The watchdog counts TMO_CYC cycles in WAIT.
//   - If CUs are still outstanding at that point, it pulses tmo_err.
//   - It then drops the outstanding CUs and finishes the tile.
//   Without the macro, no counter is built. WAIT lasts until all CUs are done.
// -----------------------------------------------------------------------------
module wkld_dispatcher #(
    parameter int M         = 16,
    parameter int N_PE      = 4,
    parameter int DW_ROWIDX = 4,
    parameter int DW_ELEIDX = 8,
    parameter int DW_MEM    = 512,
    parameter int TMO_CYC   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tile_valid,
    output logic              tile_ready,
    input  logic [DW_MEM-1:0] tile_data,
    output logic [N_PE-1:0]   cu_write_en,
    output logic [DW_MEM-1:0] cu_data,
    input  logic [N_PE-1:0]   cu_done,
    output logic              tile_done,
    output logic              busy,
    output logic              tmo_err,
    output logic [1:0]        dbg_state
);

    localparam int RP_W   = (M + 1) * DW_ELEIDX;
    localparam int R2R_W  = M * DW_ROWIDX;
    localparam int WP_LSB = RP_W + R2R_W;
    localparam int TILE_W = WP_LSB + (N_PE + 1) * DW_ROWIDX;
    localparam int IDX_W  = (N_PE > 1) ? $clog2(N_PE) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_WAIT     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [IDX_W-1:0]     pe_idx_q,  pe_idx_d;
    logic [N_PE-1:0]      pending_q, pending_d;
    logic [TILE_W-1:0]    tile_q,    tile_d;
    logic [DW_MEM-1:0]    cu_data_q, cu_data_d;

    logic [DW_ROWIDX-1:0] wk_start;
    logic [DW_ROWIDX-1:0] wk_end;
    logic [DW_MEM-1:0]    payload;
    logic                 strobe;
    logic [N_PE-1:0]      strobe_vec;
    logic                 tmo_fire;

    // Only the low TILE_W bits of the descriptor carry information.
    if (TILE_W < DW_MEM) begin : g_tile_hi
        logic unused_tile_hi;
        assign unused_tile_hi = ^tile_data[DW_MEM-1:TILE_W];
    end

    // Select the workload bounds of the CU being visited. The fixed-index loop
    // keeps every slice constant, which avoids a variable-offset part-select.
    always_comb begin
        wk_start = '0;
        wk_end   = '0;
        for (int i = 0; i < N_PE; i++) begin
            if (pe_idx_q == IDX_W'(i)) begin
                wk_start = tile_q[WP_LSB + i * DW_ROWIDX +: DW_ROWIDX];
                wk_end   = tile_q[WP_LSB + (i + 1) * DW_ROWIDX +: DW_ROWIDX];
            end
        end
    end

    // The load word reuses the descriptor's row_ptrs/row2row prefix unchanged.
    // The selected start/end pair follows it, and the upper bits are zero.
    always_comb begin
        payload                                  = '0;
        payload[WP_LSB-1:0]                      = tile_q[WP_LSB-1:0];
        payload[WP_LSB +: DW_ROWIDX]             = wk_start;
        payload[WP_LSB + DW_ROWIDX +: DW_ROWIDX] = wk_end;
    end

    assign strobe     = (state_q == S_DISPATCH) && (wk_start != wk_end);
    assign strobe_vec = strobe ? (N_PE'(1) << pe_idx_q) : '0;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TMO_CNT_W = $clog2(TMO_CYC + 1);
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TMO_CYC > 0);
`endif

    // Next-state and datapath update.
    // A completion pulse only clears a pending bit that was already set before
    // this cycle. A CU loaded in the current cycle therefore cannot be retired
    // by a cu_done pulse arriving in that same cycle.
    always_comb begin
        state_d   = state_q;
        pe_idx_d  = pe_idx_q;
        tile_d    = tile_q;
        pending_d = (pending_q & ~cu_done) | strobe_vec;
        cu_data_d = strobe ? payload : cu_data_q;
        tmo_fire  = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tile_valid) begin
                    tile_d   = tile_data[TILE_W-1:0];
                    pe_idx_d = '0;
                    state_d  = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (pe_idx_q == IDX_W'(N_PE - 1)) begin
                    pe_idx_d  = '0;
                    state_d   = S_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    pe_idx_d = pe_idx_q + 1'b1;
                end
            end
            S_WAIT: begin
`ifdef DISPATCH_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // This is the TMO_CYC-th WAIT cycle. If CUs are still outstanding,
                // give up on them.
                if ((pending_d != '0) && (tmo_cnt_q == TMO_CNT_W'(TMO_CYC - 1))) begin
                    tmo_fire  = 1'b1;
                    pending_d = '0;
                end
`endif
                // The check uses the post-completion view. A tile whose last
                // done arrives now (or an all-empty tile) finishes next cycle.
                if (pending_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pe_idx_q  <= '0;
            pending_q <= '0;
            tile_q    <= '0;
            cu_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pe_idx_q  <= pe_idx_d;
            pending_q <= pending_d;
            tile_q    <= tile_d;
            cu_data_q <= cu_data_d;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
    assign tmo_err = !reset && tmo_fire;
`else
    assign tmo_err = 1'b0;
`endif

    // Outputs are forced quiet while reset is high. This holds even in the
    // cycle where reset rises mid-dispatch, before the state register has been
    // cleared.
    assign tile_ready  = !reset && (state_q == S_IDLE);
    assign busy        = !reset && (state_q != S_IDLE);
    assign tile_done   = !reset && (state_q == S_DONE);
    assign cu_write_en = reset ? '0 : strobe_vec;
    assign cu_data     = reset ? '0 : cu_data_d;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_wkld_dispatcher.sv
module tb_wkld_dispatcher;

    localparam int M         = 16;
    localparam int N_PE      = 4;
    localparam int DW_ROWIDX = 4;
    localparam int DW_ELEIDX = 8;
    localparam int DW_MEM    = 512;
    localparam int TMO_CYC   = 16;
    localparam int RP_W      = (M + 1) * DW_ELEIDX;
    localparam int R2R_W     = M * DW_ROWIDX;
    localparam int WP_LSB    = RP_W + R2R_W;
    localparam int PAY_W     = WP_LSB + 2 * DW_ROWIDX;

    logic              clk;
    logic              reset;
    logic              tile_valid;
    logic              tile_ready;
    logic [DW_MEM-1:0] tile_data;
    logic [N_PE-1:0]   cu_write_en;
    logic [DW_MEM-1:0] cu_data;
    logic [N_PE-1:0]   cu_done;
    logic              tile_done;
    logic              busy;
    logic              tmo_err;
    logic [1:0]        dbg_state;

    int total = 0;
    int bad   = 0;

    // Scoreboard: one entry per DISPATCH cycle, {cu_write_en, cu_data}.
    logic [N_PE+DW_MEM-1:0] exp_q[$];

    // Reference model state.
    logic [RP_W-1:0]      m_rp;
    logic [R2R_W-1:0]     m_r2r;
    logic [DW_ROWIDX-1:0] m_wp[N_PE+1];
    logic [DW_MEM-1:0]    m_last;

    wkld_dispatcher #(
        .M(M), .N_PE(N_PE), .DW_ROWIDX(DW_ROWIDX), .DW_ELEIDX(DW_ELEIDX),
        .DW_MEM(DW_MEM), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
        .cu_write_en(cu_write_en), .cu_data(cu_data), .cu_done(cu_done),
        .tile_done(tile_done), .busy(busy), .tmo_err(tmo_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    // This task builds a random descriptor around the given workload pointers.
    // It pushes the expected load word for each DISPATCH cycle, then offers the
    // tile. exp_wait is the number of cycles tile_ready is expected to stay low.
    // On return, the bench sits at the negedge of the first DISPATCH cycle.
    task automatic send_tile(input int wp[5], input int exp_wait);
        logic [DW_MEM-1:0] t;
        logic [DW_MEM-1:0] d;
        logic [N_PE-1:0]   we;
        int                waits;
        for (int i = 0; i < DW_MEM; i++) t[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < RP_W; i++) m_rp[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < R2R_W; i++) m_r2r[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i <= N_PE; i++) m_wp[i] = DW_ROWIDX'(wp[i]);
        t[RP_W-1:0]     = m_rp;
        t[RP_W +: R2R_W] = m_r2r;
        for (int i = 0; i <= N_PE; i++) t[WP_LSB + i * DW_ROWIDX +: DW_ROWIDX] = m_wp[i];
        for (int p = 0; p < N_PE; p++) begin
            we = '0;
            if (m_wp[p] !== m_wp[p+1]) begin
                d = '0;
                d[RP_W-1:0]                         = m_rp;
                d[RP_W +: R2R_W]                    = m_r2r;
                d[WP_LSB +: DW_ROWIDX]              = m_wp[p];
                d[WP_LSB + DW_ROWIDX +: DW_ROWIDX]  = m_wp[p+1];
                we[p]  = 1'b1;
                m_last = d;
            end else begin
                d = m_last;
            end
            exp_q.push_back({we, d});
        end
        tile_valid = 1'b1;
        tile_data  = t;
        waits      = 0;
        while (tile_ready !== 1'b1 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        total++;
        if (waits !== exp_wait) begin
            bad++;
            $display("FAIL accept_wait: got %0d cycles, expected %0d", waits, exp_wait);
        end
        @(negedge clk);
        tile_valid = 1'b0;
        tile_data  = ~t;
    endtask

    // This task checks the N_PE DISPATCH cycles against the scoreboard.
    // same_mask pulses cu_done[i] in the cycle CU i is loaded; those pulses
    // must be ignored. late_mask pulses cu_done[i] one cycle after the load.
    // It also checks the first WAIT cycle. On return, the bench sits at the
    // negedge of the cycle after that.
    task automatic run_dispatch(input logic [N_PE-1:0] same_mask, input logic [N_PE-1:0] late_mask);
        logic [N_PE+DW_MEM-1:0] e;
        logic [N_PE+DW_MEM-1:0] got;
        for (int i = 0; i < N_PE; i++) begin
            got = {cu_write_en, cu_data};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dispatch_pe%0d: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL dispatch_pe%0d: got we=%b start=%0d end=%0d, expected we=%b start=%0d end=%0d, other fields %s",
                             i, got[DW_MEM +: N_PE], got[WP_LSB +: DW_ROWIDX], got[WP_LSB + DW_ROWIDX +: DW_ROWIDX],
                             e[DW_MEM +: N_PE], e[WP_LSB +: DW_ROWIDX], e[WP_LSB + DW_ROWIDX +: DW_ROWIDX],
                             ((got[WP_LSB-1:0] === e[WP_LSB-1:0]) && (got[DW_MEM-1:PAY_W] === e[DW_MEM-1:PAY_W])) ? "match" : "differ");
                end
            end
            total++;
            if ({busy, tile_ready, tile_done} !== 3'b100) begin
                bad++;
                $display("FAIL dispatch_flags%0d: got busy/ready/done=%b, expected 100", i, {busy, tile_ready, tile_done});
            end
            cu_done = (same_mask & (N_PE'(1) << i)) | ((i > 0) ? (late_mask & (N_PE'(1) << (i - 1))) : '0);
            @(negedge clk);
        end
        total++;
        if ({busy, tile_done, cu_write_en} !== {1'b1, 1'b0, {N_PE{1'b0}}}) begin
            bad++;
            $display("FAIL wait_entry: got busy/done/we=%b, expected 100000", {busy, tile_done, cu_write_en});
        end
        total++;
        if (cu_data !== m_last) begin
            bad++;
            $display("FAIL cu_data_hold: got start=%0d end=%0d, expected start=%0d end=%0d",
                     cu_data[WP_LSB +: DW_ROWIDX], cu_data[WP_LSB + DW_ROWIDX +: DW_ROWIDX],
                     m_last[WP_LSB +: DW_ROWIDX], m_last[WP_LSB + DW_ROWIDX +: DW_ROWIDX]);
        end
        cu_done = late_mask & (N_PE'(1) << (N_PE - 1));
        @(negedge clk);
        cu_done = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset      = 1'b1;
        tile_valid = 1'b1;
        for (int i = 0; i < DW_MEM; i++) tile_data[i] = 1'($urandom_range(0, 1));
        cu_done    = '1;
        repeat (3) @(negedge clk);
        total++;
        if ({cu_write_en, tile_done, busy, tmo_err} !== '0 || cu_data !== '0) begin
            bad++;
            $display("FAIL reset_during: got we/done/busy/tmo=%b cu_data_zero=%b, expected all 0",
                     {cu_write_en, tile_done, busy, tmo_err}, cu_data === '0);
        end
        reset      = 1'b0;
        tile_valid = 1'b0;
        cu_done    = '0;
        m_last     = '0;
        @(negedge clk);
        total++;
        if (tile_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b, expected 1", tile_ready);
        end
        total++;
        if ({cu_write_en, tile_done, busy, tmo_err} !== '0 || cu_data !== '0) begin
            bad++;
            $display("FAIL reset_after: got we/done/busy/tmo=%b, expected all 0", {cu_write_en, tile_done, busy, tmo_err});
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_accept: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_uniform();
        send_tile('{0, 4, 8, 12, 16}, 0);
        run_dispatch('0, 4'b1111);
        total++;
        if ({tile_done, busy, tile_ready} !== 3'b110) begin
            bad++;
            $display("FAIL uniform_done: got done/busy/ready=%b, expected 110", {tile_done, busy, tile_ready});
        end
        @(negedge clk);
        total++;
        if ({tile_done, busy, tile_ready} !== 3'b001) begin
            bad++;
            $display("FAIL uniform_idle: got done/busy/ready=%b, expected 001", {tile_done, busy, tile_ready});
        end
    endtask

    task automatic test_sparse();
        send_tile('{0, 0, 8, 8, 16}, 0);
        run_dispatch('0, '0);
        total++;
        if ({tile_done, busy} !== 2'b01) begin
            bad++;
            $display("FAIL sparse_wait: got done/busy=%b, expected 01", {tile_done, busy});
        end
        cu_done = 4'b0010;
        @(negedge clk);
        cu_done = 4'b0001;
        total++;
        if ({tile_done, busy} !== 2'b01) begin
            bad++;
            $display("FAIL sparse_after_pe1: got done/busy=%b, expected 01", {tile_done, busy});
        end
        @(negedge clk);
        cu_done = 4'b1000;
        total++;
        if ({tile_done, busy} !== 2'b01) begin
            bad++;
            $display("FAIL sparse_unpending_ignored: got done/busy=%b, expected 01", {tile_done, busy});
        end
        @(negedge clk);
        cu_done = '0;
        total++;
        if (tile_done !== 1'b1) begin
            bad++;
            $display("FAIL sparse_done: got %b, expected 1", tile_done);
        end
        @(negedge clk);
        total++;
        if (tile_ready !== 1'b1) begin
            bad++;
            $display("FAIL sparse_ready: got %b, expected 1", tile_ready);
        end
    endtask

    task automatic test_all_empty();
        send_tile('{5, 5, 5, 5, 5}, 0);
        run_dispatch('0, '0);
        total++;
        if (tile_done !== 1'b1) begin
            bad++;
            $display("FAIL empty_done_cycle6: got %b, expected 1", tile_done);
        end
        @(negedge clk);
        total++;
        if ({tile_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL empty_ready_cycle7: got ready/busy=%b, expected 10", {tile_ready, busy});
        end
    endtask

    task automatic test_multi_done();
        send_tile('{0, 4, 8, 12, 16}, 0);
        run_dispatch(4'b1111, '0);
        total++;
        if ({tile_done, busy} !== 2'b01) begin
            bad++;
            $display("FAIL same_cycle_done_ignored: got done/busy=%b, expected 01", {tile_done, busy});
        end
        @(negedge clk);
        cu_done = 4'b1111;
        @(negedge clk);
        cu_done = '0;
        total++;
        if (tile_done !== 1'b1) begin
            bad++;
            $display("FAIL multi_done: got %b, expected 1", tile_done);
        end
        @(negedge clk);
        cu_done = 4'b0100;
        @(negedge clk);
        cu_done = '0;
        total++;
        if ({tile_ready, busy, tile_done, cu_write_en} !== {3'b100, 4'b0000}) begin
            bad++;
            $display("FAIL idle_spurious_done: got ready/busy/done/we=%b, expected 1000000", {tile_ready, busy, tile_done, cu_write_en});
        end
    endtask

    task automatic test_back_to_back();
        send_tile('{1, 6, 7, 11, 14}, 0);
        run_dispatch('0, 4'b1111);
        total++;
        if ({tile_done, tile_ready} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_first_done: got done/ready=%b, expected 10", {tile_done, tile_ready});
        end
        send_tile('{2, 3, 3, 9, 15}, 1);
        run_dispatch('0, 4'b1111);
        total++;
        if (tile_done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_done: got %b, expected 1", tile_done);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        send_tile('{0, 4, 8, 12, 16}, 0);
        run_dispatch('0, 4'b1110);
`ifdef DISPATCH_TIMEOUT_EN
        begin
            int seen;
            seen = -1;
            for (int k = 0; k < 40 && seen < 0; k++) begin
                if (tmo_err === 1'b1) seen = k;
                else @(negedge clk);
            end
            total++;
            if (seen != TMO_CYC - 2) begin
                bad++;
                $display("FAIL tmo_pulse_cycle: got offset %0d, expected %0d", seen, TMO_CYC - 2);
            end
            @(negedge clk);
            total++;
            if ({tile_done, tmo_err} !== 2'b10) begin
                bad++;
                $display("FAIL tmo_then_done: got done/tmo=%b, expected 10", {tile_done, tmo_err});
            end
            @(negedge clk);
        end
`else
        begin
            int errs;
            errs = 0;
            repeat (100) begin
                if (busy !== 1'b1 || tile_done !== 1'b0 || tmo_err !== 1'b0) errs++;
                @(negedge clk);
            end
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL wait_persists: got %0d bad cycles, expected 0", errs);
            end
            cu_done = 4'b0001;
            @(negedge clk);
            cu_done = '0;
            total++;
            if (tile_done !== 1'b1) begin
                bad++;
                $display("FAIL late_release_done: got %b, expected 1", tile_done);
            end
            @(negedge clk);
        end
`endif
        total++;
        if (tile_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_ready: got %b, expected 1", tile_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [N_PE+DW_MEM-1:0] e;
        int                     errs;
        send_tile('{0, 4, 8, 12, 16}, 0);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            total++;
            if ({cu_write_en, cu_data} !== e) begin
                bad++;
                $display("FAIL rmid_strobe%0d: got we=%b, expected we=%b", i, cu_write_en, e[DW_MEM +: N_PE]);
            end
            if (i == 1) reset = 1'b1;
            @(negedge clk);
        end
        exp_q.delete();
        m_last = '0;
        total++;
        if ({cu_write_en, busy, tile_done} !== '0 || cu_data !== '0) begin
            bad++;
            $display("FAIL rmid_during: got we/busy/done=%b, expected 0", {cu_write_en, busy, tile_done});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({tile_ready, busy} !== 2'b10 || cu_data !== '0) begin
            bad++;
            $display("FAIL rmid_after: got ready/busy=%b, expected 10", {tile_ready, busy});
        end
        errs = 0;
        repeat (6) begin
            if (cu_write_en !== '0 || busy !== 1'b0) errs++;
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL rmid_quiet: got %0d active cycles, expected 0", errs);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset      = 1'b1;
        tile_valid = 1'b0;
        tile_data  = '0;
        cu_done    = '0;
        m_last     = '0;
        @(negedge clk);
        test_reset();
        test_uniform();
        test_sparse();
        test_all_empty();
        test_multi_done();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
